// File: rtl/custom_types.sv
// Shared types for the 4-bit CPU slice: instruction word and program loader FSM states.
package custom_types;

    typedef logic [7:0] instruction_t;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_COUNT,
        LD_DATA,
        LD_CHECK,
        LD_DONE
    } loader_state_t;

    localparam instruction_t LOADER_HEADER = 8'hA5;

endpackage

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: writes instruction memory and holds the CPU
// in reset until the frame checksum verifies.
module prog_loader
    import custom_types::*;
#(
    parameter logic [7:0] HEADER = LOADER_HEADER
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         imem_we,
    output logic [3:0]   imem_addr,
    output instruction_t imem_wdata,
    output logic         cpu_hold,
    output logic         load_done,
    output logic         load_err
);

    loader_state_t state;
    logic [7:0]    acc;
    logic [3:0]    addr;
    logic [3:0]    remaining;
    logic          accept;

    assign in_ready = (state != LD_DONE);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LD_IDLE;
            acc        <= '0;
            addr       <= '0;
            remaining  <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                LD_IDLE: begin
                    if (accept && in_data == HEADER) begin
                        state    <= LD_COUNT;
                        cpu_hold <= 1'b1;
                        load_err <= 1'b0;
                        acc      <= '0;
                    end
                end
                LD_COUNT: begin
                    if (accept) begin
                        if (in_data[7:4] != 4'd0) begin
                            load_err <= 1'b1;
                            state    <= LD_IDLE;
                        end else begin
                            remaining <= in_data[3:0];
                            addr      <= '0;
                            acc       <= in_data;
                            state     <= LD_DATA;
                        end
                    end
                end
                LD_DATA: begin
                    if (accept) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= addr;
                        imem_wdata <= in_data;
                        acc        <= acc ^ in_data;
                        addr       <= addr + 4'd1;
                        if (remaining == 4'd0) begin
                            state <= LD_CHECK;
                        end else begin
                            remaining <= remaining - 4'd1;
                        end
                    end
                end
                LD_CHECK: begin
                    // memory is already partly rewritten, so a mismatch keeps the CPU held
                    if (accept) begin
                        if (in_data == acc) begin
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                            state     <= LD_DONE;
                        end else begin
                            load_err <= 1'b1;
                            state    <= LD_IDLE;
                        end
                    end
                end
                LD_DONE: begin
                    load_done <= 1'b0;
                    state     <= LD_IDLE;
                end
                default: state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: per-cycle vector table plus multi-cycle frame sequences.
module tb_prog_loader;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       imem_we;
    logic [3:0] imem_addr;
    logic [7:0] imem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    prog_loader #(.HEADER(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // write / done log captured from the registered outputs at each rising edge
    logic [3:0] log_addr [256];
    logic [7:0] log_data [256];
    int         wr_total = 0;
    int         done_total = 0;

    always @(posedge clk) begin
        if (imem_we) begin
            log_addr[wr_total % 256] = imem_addr;
            log_data[wr_total % 256] = imem_wdata;
            wr_total = wr_total + 1;
        end
        if (load_done) done_total = done_total + 1;
    end

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       we;
        logic [3:0] a;
        logic [7:0] wd;
        logic       hold;
        logic       done;
        logic       err;
        logic       rdy;
    } vec_t;

    vec_t       tbl [32];
    int         nvec = 0;
    logic [7:0] frame_buf [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic we,
                                input logic [3:0] a, input logic [7:0] wd, input logic hold,
                                input logic done, input logic err, input logic rdy);
        tbl[nvec] = '{v, d, we, a, wd, hold, done, err, rdy};
        nvec = nvec + 1;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        if (n >= 20) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL ready_timeout: in_ready stuck at 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // full frame of n bytes from frame_buf; gaps on odd bytes when gap_mode set
    task automatic send_frame(input int n, input bit gap_mode, input string tag);
        logic [7:0] cnt;
        logic [7:0] cs;
        int wbase;
        int dbase;
        cnt   = 8'(n - 1);
        cs    = cnt;
        for (int i = 0; i < n; i++) cs = cs ^ frame_buf[i];
        wbase = wr_total;
        dbase = done_total;
        send_byte(8'hA5, 0);
        chk({tag, "_hold_on_header"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_err_clr_header"}, 32'(load_err), 32'd0);
        send_byte(cnt, gap_mode ? 1 : 0);
        for (int i = 0; i < n; i++) send_byte(frame_buf[i], (gap_mode && (i % 2 == 1)) ? 2 : 0);
        chk({tag, "_hold_before_chk"}, 32'(cpu_hold), 32'd1);
        send_byte(cs, 0);
        chk({tag, "_hold_fall_chk"}, 32'(cpu_hold), 32'd0);
        chk({tag, "_done_pulse"}, 32'(load_done), 32'd1);
        chk({tag, "_ready_done"}, 32'(in_ready), 32'd0);
        chk({tag, "_wr_count"}, 32'(wr_total - wbase), 32'(n));
        for (int k = 0; k < n && k < wr_total - wbase; k++) begin
            chk({tag, "_wr_addr"}, 32'(log_addr[(wbase + k) % 256]), 32'(k));
            chk({tag, "_wr_data"}, 32'(log_data[(wbase + k) % 256]), 32'(frame_buf[k]));
        end
        @(posedge clk);
        #1;
        chk({tag, "_done_clear"}, 32'(load_done), 32'd0);
        chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        chk({tag, "_done_count"}, 32'(done_total - dbase), 32'd1);
        chk({tag, "_err_final"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #12;
        chk("rst_hold", 32'(cpu_hold), 32'd1);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", 32'(imem_wdata), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        //   v   data   we  a     wd     hold done err rdy
        add(1, 8'h00, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // noise dropped
        add(1, 8'hFF, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // noise dropped
        add(1, 8'hA5, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // header
        add(1, 8'h01, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // N=2
        add(1, 8'h12, 1, 4'h0, 8'h12, 1, 0, 0, 1);
        add(0, 8'h00, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // valid gap
        add(1, 8'h34, 1, 4'h1, 8'h34, 1, 0, 0, 1);
        add(1, 8'h00, 0, 4'h0, 8'h00, 1, 0, 1, 1);   // bad CHK (want 27)
        add(1, 8'h10, 0, 4'h0, 8'h00, 1, 0, 1, 1);   // dropped in IDLE, err sticky
        add(1, 8'hA5, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // header clears err
        add(1, 8'h10, 0, 4'h0, 8'h00, 1, 0, 1, 1);   // bad count
        add(1, 8'hA5, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // back in IDLE: header accepted
        add(1, 8'h00, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // N=1
        add(1, 8'h5C, 1, 4'h0, 8'h5C, 1, 0, 0, 1);
        add(1, 8'h5C, 0, 4'h0, 8'h00, 0, 1, 0, 0);   // good CHK -> DONE
        add(1, 8'hA5, 0, 4'h0, 8'h00, 0, 0, 0, 1);   // not accepted in DONE
        add(1, 8'hA5, 0, 4'h0, 8'h00, 1, 0, 0, 1);   // reload while CPU runs
        add(1, 8'h00, 0, 4'h0, 8'h00, 1, 0, 0, 1);
        add(1, 8'h77, 1, 4'h0, 8'h77, 1, 0, 0, 1);
        add(1, 8'h77, 0, 4'h0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h00, 0, 4'h0, 8'h00, 0, 0, 0, 1);

        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_we", i), 32'(imem_we), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tbl[i].a));
                chk($sformatf("vec%0d_wdata", i), 32'(imem_wdata), 32'(tbl[i].wd));
            end
            chk($sformatf("vec%0d_hold", i), 32'(cpu_hold), 32'(tbl[i].hold));
            chk($sformatf("vec%0d_done", i), 32'(load_done), 32'(tbl[i].done));
            chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(tbl[i].err));
            chk($sformatf("vec%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
        end
        in_valid = 1'b0;

        // program 1: 12 instructions, continuous valid, CPU running when header arrives
        frame_buf = '{8'h1F, 8'h20, 8'h31, 8'h42, 8'h53, 8'h64, 8'h75, 8'h86,
                      8'h97, 8'hA5, 8'hB9, 8'hCA, 8'h00, 8'h00, 8'h00, 8'h00};
        send_frame(12, 1'b0, "prog1");

        // 16-instruction frame with valid gaps
        for (int i = 0; i < 16; i++) frame_buf[i] = 8'((i * 17) ^ 8'h3C);
        send_frame(16, 1'b1, "full16");

        // reset asserted after the 3rd data byte
        wbase = wr_total;
        send_byte(8'hA5, 0);
        send_byte(8'h07, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        chk("mid_we_before_rst", 32'(imem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
        chk("mid_rst_we", 32'(imem_we), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_writes", 32'(wr_total - wbase), 32'd2);
        frame_buf[0] = 8'hA5;
        frame_buf[1] = 8'h0E;
        frame_buf[2] = 8'hD3;
        frame_buf[3] = 8'h48;
        send_frame(4, 1'b1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that sits directly upstream of `cpu_4bit`. It accepts a framed byte stream over a valid/ready interface and writes the instructions into the CPU's instruction memory write port. It holds the CPU in reset while loading and releases it only after the frame checksum verifies. It replaces testbench back-door writes into `instr_mem.mem` with a real load path.

## Interface
Parameters:
- `HEADER`, default 8'hA5: frame start byte.

Ports (the clock is `clk`; the reset is `reset`, asynchronous and active-high):
- `clk` in 1: the single clock, shared with `cpu_4bit`.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: the source presents a byte.
- `in_data` in 8: the stream byte.
- `in_ready` out 1: the loader accepts a byte when `in_valid && in_ready` at a rising edge.
- `imem_we` out 1: instruction memory write enable, registered.
- `imem_addr` out 4: instruction memory write address, registered.
- `imem_wdata` out `instruction_t` (8 bits): the instruction to write, registered.
- `cpu_hold` out 1: drives the `cpu_4bit` reset input; 1 means the CPU is held.
- `load_done` out 1: one-cycle pulse when a load verifies.
- `load_err` out 1: sticky flag for a bad count or a bad checksum.

## Operation
- Frame format: `HEADER`, then COUNT, then N instruction bytes, then CHK.
  - COUNT[7:4] must be 0. N = COUNT[3:0] + 1, giving a range of 1 to 16.
  - CHK = COUNT ^ data0 ^ … ^ data(N-1).
- Instruction bytes are written to addresses 0 to N-1 in order. Addresses at N and above are left untouched.
- FSM states are IDLE, COUNT, DATA, CHECK and DONE.
- **IDLE**
  - A byte equal to `HEADER` is accepted and moves the FSM to COUNT. On the same edge: `cpu_hold`<=1, `load_err`<=0, acc<=0.
  - Any other byte is accepted and dropped, with no output change.
- **COUNT**
  - If COUNT[7:4] is not 0: `load_err`<=1, go to IDLE, `cpu_hold` stays 1.
  - Otherwise: remaining<=COUNT[3:0], addr<=0, acc<=COUNT, go to DATA.
- **DATA** (per accepted byte)
  - `imem_we`<=1, `imem_addr`<=addr, `imem_wdata`<=byte.
  - acc<=acc^byte, addr<=addr+1.
  - When remaining==0, go to CHECK; otherwise remaining<=remaining-1.
- **CHECK**
  - Accepted byte equals acc: go to DONE, `cpu_hold`<=0, `load_done`<=1.
  - Mismatch: `load_err`<=1, `cpu_hold` stays 1, go to IDLE. Memory is already partly overwritten, so the CPU must not run.
- **DONE**: `in_ready`=0, clear `load_done`, go to IDLE.
- A `HEADER` byte arriving while the CPU runs (state IDLE, `cpu_hold`=0) re-asserts hold and starts a new load.
- `HEADER` bytes inside COUNT, DATA or CHECK are treated as ordinary data. There is no resynchronisation.
- Address arithmetic is 4-bit. addr wraps only after the 16th byte, and the FSM has already left DATA by then.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_hold`=1.
  - `in_ready`=1 (combinational: 0 only in DONE).
  - `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `load_done`=0, `load_err`=0.
- `imem_we` is high for exactly one cycle after each accepted data byte. The memory captures the write on the following edge.
  - Back-to-back bytes produce back-to-back writes.
  - A gap in `in_valid` deasserts `imem_we` for the gap.
- The earliest `cpu_hold` fall is the edge that accepts CHK. This is the same edge on which the last data write lands, so the CPU fetches a fully written memory.
- `load_done` is high for exactly the DONE cycle.
- A full frame with continuous valid is N+3 accepted bytes. `cpu_hold` falls at the (N+3)th acceptance edge. One bubble (DONE) follows before the next byte can be accepted.
- Reset asserted mid-frame aborts immediately to the reset values. Writes already performed remain in memory.

## Structure
- Add to the `custom_types` package:
  - `loader_state_t`, an enum of the five states.
  - `LOADER_HEADER` = 8'hA5.
- Reuse `instruction_t` from the package.
- No sub-module: a single FSM with acc/addr/remaining registers.
- Integration: `cpu_4bit` gains an instruction memory write port. Its reset input is `reset | cpu_hold`.

## Test plan
- Load program 1: header, 8'h0B, 12 bytes, correct CHK. Required: 12 writes to addresses 0–11 with the exact bytes; `cpu_hold` falls on the CHK edge; `load_done` pulses once; the CPU then leaves R3=15 and data memory mem[i]=i for i=0–14.
- Bad checksum: header, 8'h01, 8'h12, 8'h34, CHK=8'h00 (correct value 8'h27). Required: writes to addresses 0 and 1, `load_err`=1, `cpu_hold` stays 1, `load_done` stays 0.
- Bad count 8'h10. Required: `load_err`=1, no writes, state IDLE. A following valid frame clears `load_err` on its header.
- Noise bytes 8'h00 and 8'hFF before the header are dropped with no writes. A 16-instruction frame (COUNT 8'h0F) writes addresses 0–15.
- Reset asserted after the 3rd data byte. Required: `cpu_hold`=1 and `imem_we`=0 immediately; a new full frame then loads correctly.
- Reload while the CPU runs: a header arrives with `cpu_hold`=0. Required: hold re-asserts on that edge; `in_ready` is 0 for exactly the DONE cycle; `in_valid` gaps stretch the frame without duplicate writes.
